// File: rtl/password_lock_fsm_pkg.sv
// Shared definitions for the password lock engine: state codes and
// constant helpers used to size counters from the timing parameters.
package password_lock_fsm_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        int rest;
        bits = 0;
        rest = value - 1;
        while (rest > 0) begin
            bits = bits + 1;
            rest = rest >> 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/password_lock_fsm_press_detect.sv
// Turns debounced switch levels into single press strobes. A press is the
// first cycle any switch is high after all switches were low; the switch
// index becomes the digit, and multi-hot patterns are flagged invalid.
module onehot_press_detect
    import password_lock_fsm_pkg::*;
#(
    parameter int BIT_SIZE = 10,
    parameter int DIGIT_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIT_SIZE-1:0] sw,
    output logic                press,
    output logic                valid,
    output logic [DIGIT_W-1:0]  digit
);

    logic [BIT_SIZE-1:0] sw_q;

    // Remember last cycle's switches so a held switch yields only one press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_q <= '0;
        end else begin
            sw_q <= sw;
        end
    end

    // Edge detect, one-hot check and index encoding of the pressed switch.
    always_comb begin
        press = (sw != '0) && (sw_q == '0);
        valid = (sw != '0) && ((sw & (sw - BIT_SIZE'(1))) == '0);
        digit = '0;
        for (int i = 0; i < BIT_SIZE; i++) begin
            if (sw[i]) begin
                digit = DIGIT_W'(i);
            end
        end
    end

endmodule

// File: rtl/password_lock_fsm.sv
// Password-check engine: compares an N-digit keyed sequence against a fixed
// code, shows the result for a fixed time, counts consecutive failures and
// locks the keypad out after too many. An idle entry is abandoned on timeout.
module password_lock_fsm
    import password_lock_fsm_pkg::*;
#(
    parameter int                        N_DIGITS       = 4,
    parameter int                        BIT_SIZE       = 10,
    parameter int                        DIGIT_W        = 4,
    parameter logic [N_DIGITS*DIGIT_W-1:0] PASSWORD     = 16'h6102,
    parameter bit                        EARLY_REJECT   = 1'b1,
    parameter int                        MAX_FAILS      = 3,
    parameter int                        OPEN_CYCLES    = 50_000_000,
    parameter int                        FAIL_CYCLES    = 50_000_000,
    parameter int                        LOCKOUT_CYCLES = 500_000_000,
    parameter int                        ENTRY_TIMEOUT  = 250_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BIT_SIZE-1:0]               sw,
    output logic                              unlocked,
    output logic                              fail,
    output logic                              locked_out,
    output logic                              timeout,
    output logic [clog2(N_DIGITS+1)-1:0]      digits_entered,
    output logic [clog2(MAX_FAILS+1)-1:0]     fail_count,
    output logic [2:0]                        state
);

    localparam int DE_W  = clog2(N_DIGITS + 1);
    localparam int FC_W  = clog2(MAX_FAILS + 1);
    localparam int TMR_W = clog2(max2(max2(OPEN_CYCLES, FAIL_CYCLES),
                                      max2(LOCKOUT_CYCLES, ENTRY_TIMEOUT)));

    logic               press;
    logic               valid;
    logic [DIGIT_W-1:0] digit;

    logic               err;
    logic [TMR_W-1:0]   timer;

    logic [2:0]         state_next;
    logic [DE_W-1:0]    de_next;
    logic [DE_W-1:0]    de_inc;
    logic [FC_W-1:0]    fc_next;
    logic [FC_W-1:0]    fc_inc;
    logic               err_next;
    logic               timeout_next;
    logic [DIGIT_W-1:0] expected;
    logic               mismatch;
    logic               go_result;
    logic               result_bad;

    onehot_press_detect #(
        .BIT_SIZE (BIT_SIZE),
        .DIGIT_W  (DIGIT_W)
    ) u_press (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .press (press),
        .valid (valid),
        .digit (digit)
    );

    // Next-state and counter decisions; entries that finish funnel into a
    // common result step that picks OPEN, FAIL or LOCKOUT.
    always_comb begin
        state_next   = state;
        de_next      = digits_entered;
        err_next     = err;
        fc_next      = fail_count;
        timeout_next = 1'b0;
        go_result    = 1'b0;
        result_bad   = 1'b0;
        de_inc       = digits_entered + DE_W'(1);
        fc_inc       = fail_count + FC_W'(1);

        expected = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (digits_entered == DE_W'(d)) begin
                expected = PASSWORD[d*DIGIT_W +: DIGIT_W];
            end
        end
        mismatch = !valid || (digit != expected);

        case (state)
            S_IDLE: begin
                if (press) begin
                    de_next  = DE_W'(1);
                    err_next = mismatch;
                    if ((EARLY_REJECT && mismatch) || (N_DIGITS == 1)) begin
                        go_result  = 1'b1;
                        result_bad = mismatch;
                    end else begin
                        state_next = S_ENTRY;
                    end
                end
            end
            S_ENTRY: begin
                if (press) begin
                    de_next  = de_inc;
                    err_next = err | mismatch;
                    if ((EARLY_REJECT && mismatch) || (de_inc == DE_W'(N_DIGITS))) begin
                        go_result  = 1'b1;
                        result_bad = err | mismatch;
                    end
                end else if (timer == TMR_W'(ENTRY_TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = S_IDLE;
                end
            end
            S_OPEN: begin
                if (timer == TMR_W'(OPEN_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end
            end
            S_FAIL: begin
                if (timer == TMR_W'(FAIL_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (timer == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                    state_next = S_IDLE;
                    fc_next    = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (go_result) begin
            if (result_bad) begin
                fc_next    = fc_inc;
                state_next = (fc_inc == FC_W'(MAX_FAILS)) ? S_LOCKOUT : S_FAIL;
            end else begin
                fc_next    = '0;
                state_next = S_OPEN;
            end
        end

        if (state_next == S_IDLE) begin
            de_next  = '0;
            err_next = 1'b0;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            digits_entered <= '0;
            fail_count     <= '0;
            err            <= 1'b0;
            unlocked       <= 1'b0;
            fail           <= 1'b0;
            locked_out     <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            state          <= state_next;
            digits_entered <= de_next;
            fail_count     <= fc_next;
            err            <= err_next;
            unlocked       <= (state_next == S_OPEN);
            fail           <= (state_next == S_FAIL);
            locked_out     <= (state_next == S_LOCKOUT);
            timeout        <= timeout_next;
        end
    end

    // Shared hold/idle timer: restarts on any state change or accepted digit
    // and sticks at full scale rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if ((state_next != state) || ((state == S_ENTRY) && press)) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + TMR_W'(1);
        end
    end

endmodule

// File: tb/tb_password_lock_fsm.sv
// Directed bench for password_lock_fsm: one early-reject instance and one
// deferred-reject instance, short hold times, code 2-0-1-6.
module tb_password_lock_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] sw_e = '0;
    logic [9:0] sw_d = '0;

    logic       unlocked_e, fail_e, locked_out_e, timeout_e;
    logic [2:0] de_e;
    logic [1:0] fc_e;
    logic [2:0] state_e;

    logic       unlocked_d, fail_d, locked_out_d, timeout_d;
    logic [2:0] de_d;
    logic [1:0] fc_d;
    logic [2:0] state_d;

    int checks = 0;
    int errors = 0;

    password_lock_fsm #(
        .N_DIGITS(4), .BIT_SIZE(10), .DIGIT_W(4), .PASSWORD(16'h6102),
        .EARLY_REJECT(1'b1), .MAX_FAILS(3), .OPEN_CYCLES(8), .FAIL_CYCLES(4),
        .LOCKOUT_CYCLES(16), .ENTRY_TIMEOUT(40)
    ) dut_e (
        .clk(clk), .rst(rst), .sw(sw_e), .unlocked(unlocked_e), .fail(fail_e),
        .locked_out(locked_out_e), .timeout(timeout_e), .digits_entered(de_e),
        .fail_count(fc_e), .state(state_e)
    );

    password_lock_fsm #(
        .N_DIGITS(4), .BIT_SIZE(10), .DIGIT_W(4), .PASSWORD(16'h6102),
        .EARLY_REJECT(1'b0), .MAX_FAILS(3), .OPEN_CYCLES(8), .FAIL_CYCLES(4),
        .LOCKOUT_CYCLES(16), .ENTRY_TIMEOUT(40)
    ) dut_d (
        .clk(clk), .rst(rst), .sw(sw_d), .unlocked(unlocked_d), .fail(fail_d),
        .locked_out(locked_out_d), .timeout(timeout_d), .digits_entered(de_d),
        .fail_count(fc_d), .state(state_d)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] oh(input int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    task automatic hit(input logic [9:0] v);
        sw_e = v;
        @(posedge clk); #1;
    endtask

    task automatic press(input int d);
        hit(oh(d));
        sw_e = '0;
        @(posedge clk); #1;
    endtask

    task automatic hit_d(input logic [9:0] v);
        sw_d = v;
        @(posedge clk); #1;
    endtask

    task automatic press_d(input int d);
        hit_d(oh(d));
        sw_d = '0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Cycles spent before the early-reject instance is back in IDLE (bounded).
    task automatic run_until_idle(output int n);
        n = 0;
        while (state_e !== 3'd0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; sw_e = '0; sw_d = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({unlocked_e, fail_e, locked_out_e, timeout_e} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags_e actual=%b expected=0000", {unlocked_e, fail_e, locked_out_e, timeout_e}); end
        checks++; if (state_e !== 3'd0 || de_e !== 3'd0 || fc_e !== 2'd0) begin errors++; $display("[TB] FAIL reset_regs_e state=%0d de=%0d fc=%0d expected 0 0 0", state_e, de_e, fc_e); end
        checks++; if ({unlocked_d, fail_d, locked_out_d, timeout_d} !== 4'b0000 || state_d !== 3'd0) begin errors++; $display("[TB] FAIL reset_d flags=%b state=%0d expected 0000 0", {unlocked_d, fail_d, locked_out_d, timeout_d}, state_d); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (state_e !== 3'd0) begin errors++; $display("[TB] FAIL reset_release_state actual=%0d expected=0", state_e); end
    endtask

    task automatic test_correct_code();
        int n;
        do_reset();
        press(2);
        checks++; if (state_e !== 3'd1 || de_e !== 3'd1) begin errors++; $display("[TB] FAIL first_digit state=%0d de=%0d expected 1 1", state_e, de_e); end
        press(0);
        press(1);
        checks++; if (de_e !== 3'd3 || unlocked_e !== 1'b0) begin errors++; $display("[TB] FAIL three_digits de=%0d unlocked=%b expected 3 0", de_e, unlocked_e); end
        hit(oh(6));
        checks++; if (unlocked_e !== 1'b1 || state_e !== 3'd2 || fc_e !== 2'd0) begin errors++; $display("[TB] FAIL open unlocked=%b state=%0d fc=%0d expected 1 2 0", unlocked_e, state_e, fc_e); end
        sw_e = '0;
        run_until_idle(n);
        checks++; if (n !== 8) begin errors++; $display("[TB] FAIL open_length actual=%0d expected=8", n); end
        checks++; if (unlocked_e !== 1'b0 || de_e !== 3'd0) begin errors++; $display("[TB] FAIL open_exit unlocked=%b de=%0d expected 0 0", unlocked_e, de_e); end
    endtask

    task automatic test_early_reject();
        int n;
        do_reset();
        press(2);
        press(0);
        checks++; if (fail_e !== 1'b0) begin errors++; $display("[TB] FAIL early_before fail=%b expected=0", fail_e); end
        hit(oh(2));
        checks++; if (fail_e !== 1'b1 || fc_e !== 2'd1 || state_e !== 3'd3) begin errors++; $display("[TB] FAIL early_reject fail=%b fc=%0d state=%0d expected 1 1 3", fail_e, fc_e, state_e); end
        sw_e = '0;
        run_until_idle(n);
        checks++; if (n !== 4 || fc_e !== 2'd1) begin errors++; $display("[TB] FAIL fail_length n=%0d fc=%0d expected 4 1", n, fc_e); end
        press_d(2);
        press_d(0);
        hit_d(oh(2));
        checks++; if (fail_d !== 1'b0 || state_d !== 3'd1 || de_d !== 3'd3) begin errors++; $display("[TB] FAIL deferred_third fail=%b state=%0d de=%0d expected 0 1 3", fail_d, state_d, de_d); end
        sw_d = '0;
        @(posedge clk); #1;
        hit_d(oh(6));
        checks++; if (fail_d !== 1'b1 || fc_d !== 2'd1 || unlocked_d !== 1'b0) begin errors++; $display("[TB] FAIL deferred_fourth fail=%b fc=%0d unlocked=%b expected 1 1 0", fail_d, fc_d, unlocked_d); end
        sw_d = '0;
    endtask

    task automatic test_lockout();
        int n;
        int code[4] = '{2, 0, 1, 6};
        logic saw_open;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            hit(oh(1));
            checks++; if (fail_e !== 1'b1 || fc_e !== 2'(i + 1)) begin errors++; $display("[TB] FAIL wrong_entry_%0d fail=%b fc=%0d expected 1 %0d", i, fail_e, fc_e, i + 1); end
            sw_e = '0;
            run_until_idle(n);
        end
        hit(oh(1));
        checks++; if (locked_out_e !== 1'b1 || fail_e !== 1'b0 || fc_e !== 2'd3 || state_e !== 3'd4) begin errors++; $display("[TB] FAIL lockout_entry lo=%b fail=%b fc=%0d state=%0d expected 1 0 3 4", locked_out_e, fail_e, fc_e, state_e); end
        n = 0;
        saw_open = 1'b0;
        while (locked_out_e === 1'b1 && n < 40) begin
            n++;
            sw_e = (n < 9 && (n % 2) == 1) ? oh(code[n / 2]) : 10'd0;
            @(posedge clk); #1;
            if (unlocked_e === 1'b1) saw_open = 1'b1;
        end
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL lockout_length actual=%0d expected=16", n); end
        checks++; if (saw_open !== 1'b0) begin errors++; $display("[TB] FAIL lockout_ignores_presses unlocked_seen=%b expected=0", saw_open); end
        checks++; if (state_e !== 3'd0 || fc_e !== 2'd0) begin errors++; $display("[TB] FAIL lockout_exit state=%0d fc=%0d expected 0 0", state_e, fc_e); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        hit(oh(1));
        sw_e = '0;
        run_until_idle(n);
        hit(oh(2));
        checks++; if (state_e !== 3'd1 || de_e !== 3'd1) begin errors++; $display("[TB] FAIL timeout_start state=%0d de=%0d expected 1 1", state_e, de_e); end
        sw_e = '0;
        n = 0;
        while (timeout_e !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n !== 40) begin errors++; $display("[TB] FAIL timeout_delay actual=%0d expected=40", n); end
        checks++; if (state_e !== 3'd0 || de_e !== 3'd0 || fc_e !== 2'd1) begin errors++; $display("[TB] FAIL timeout_abort state=%0d de=%0d fc=%0d expected 0 0 1", state_e, de_e, fc_e); end
        @(posedge clk); #1;
        checks++; if (timeout_e !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pulse_width actual=%b expected=0", timeout_e); end
        press(2); press(0); press(1);
        hit(oh(6));
        checks++; if (unlocked_e !== 1'b1 || fc_e !== 2'd0) begin errors++; $display("[TB] FAIL after_timeout_open unlocked=%b fc=%0d expected 1 0", unlocked_e, fc_e); end
        sw_e = '0;
        run_until_idle(n);
    endtask

    task automatic test_multi_hot();
        int n;
        do_reset();
        hit(10'b0000000101);
        checks++; if (fail_e !== 1'b1 || fc_e !== 2'd1) begin errors++; $display("[TB] FAIL multi_hot fail=%b fc=%0d expected 1 1", fail_e, fc_e); end
        run_until_idle(n);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (state_e !== 3'd0 || de_e !== 3'd0) begin errors++; $display("[TB] FAIL held_switch state=%0d de=%0d expected 0 0", state_e, de_e); end
        sw_e = '0;
        @(posedge clk); #1;
        press(2); press(0); press(1);
        hit(oh(6));
        checks++; if (unlocked_e !== 1'b1) begin errors++; $display("[TB] FAIL multi_hot_recover unlocked=%b expected=1", unlocked_e); end
        sw_e = '0;
        run_until_idle(n);
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            hit(oh(1));
            sw_e = '0;
            if (i < 2) run_until_idle(n);
        end
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++; if (state_e !== 3'd0 || locked_out_e !== 1'b0 || fc_e !== 2'd0) begin errors++; $display("[TB] FAIL reset_mid_lockout state=%0d lo=%b fc=%0d expected 0 0 0", state_e, locked_out_e, fc_e); end
        @(posedge clk); #1;
        rst = 1'b1;
        press(2);
        press(0);
        #3;
        rst = 1'b0;
        #1;
        checks++; if (state_e !== 3'd0 || de_e !== 3'd0 || {unlocked_e, fail_e, timeout_e} !== 3'b000) begin errors++; $display("[TB] FAIL reset_mid_entry state=%0d de=%0d flags=%b expected 0 0 000", state_e, de_e, {unlocked_e, fail_e, timeout_e}); end
        @(posedge clk); #1;
        rst = 1'b1;
        press(2); press(0); press(1);
        hit(oh(6));
        checks++; if (unlocked_e !== 1'b1) begin errors++; $display("[TB] FAIL reset_recover unlocked=%b expected=1", unlocked_e); end
        sw_e = '0;
        run_until_idle(n);
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_early_reject();
        test_lockout();
        test_timeout();
        test_multi_hot();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

endmodule
